uart_tx_frame: RTL and testbench

UART_TX_FRAME -- requirements
Module: uart_tx_frame

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_baud_timer.sv | 27 ++
 rtl/uart_tx_frame.sv | 150 +++++++++++++++
 tb/tb_uart_tx_frame.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity selectors, transmitter states and bit timing helper.
package uart_pkg;

   localparam int unsigned PARITY_NONE = 0;
   localparam int unsigned PARITY_EVEN = 1;
   localparam int unsigned PARITY_ODD  = 2;

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StParity,
      StStop
   } tx_state_t;

   // Clocks per bit, rounded to the nearest integer.
   function automatic int unsigned bit_cycles(input int unsigned clock_frequency,
                                              input int unsigned baud_rate);
      return (clock_frequency + baud_rate / 2) / baud_rate;
   endfunction

endpackage

// File: rtl/uart_baud_timer.sv
// Per-bit clock counter: counts 0..BitCycles-1 and flags the last clock of a bit.
module uart_baud_timer #(
   parameter int unsigned BitCycles = 10
) (
   input  logic clock,
   input  logic reset,
   input  logic restart,
   output logic bitEnd
);

   localparam int unsigned CountWidth = $clog2(BitCycles);
   localparam logic [CountWidth-1:0] LastCount = CountWidth'(BitCycles - 1);

   logic [CountWidth-1:0] count_q;

   // Counter restarts at every bit boundary and is held at zero while idle.
   always_ff @(posedge clock) begin
      if (reset || restart) begin
         count_q <= '0;
      end else begin
         count_q <= count_q + CountWidth'(1);
      end
   end

   assign bitEnd = (count_q == LastCount);

endmodule

// File: rtl/uart_tx_frame.sv
// UART frame transmitter: start bit, LSB-first data, optional parity, 1 or 2 stop bits.
module uart_tx_frame
   import uart_pkg::*;
#(
   parameter int unsigned ClockFrequency = 1000000,
   parameter int unsigned BaudRate       = 9600,
   parameter int unsigned DataBits       = 8,
   parameter int unsigned ParityMode     = PARITY_NONE,
   parameter int unsigned StopBits       = 1
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                startTransmission,
   input  logic [DataBits-1:0] data,
   output logic                busy,
   output logic                done,
   output logic                tx
);

   localparam int unsigned BitCycles   = bit_cycles(ClockFrequency, BaudRate);
   localparam logic [3:0]  LastDataIdx = 4'(DataBits - 1);
   localparam logic        LastStopIdx = 1'(StopBits - 1);
   localparam logic        OddParity   = (ParityMode == PARITY_ODD);

   if (BitCycles < 2) begin : g_bad_bit_cycles
      $error("uart_tx_frame: BitCycles must be at least 2");
   end
   if (DataBits < 5 || DataBits > 9) begin : g_bad_data_bits
      $error("uart_tx_frame: DataBits must be in 5..9");
   end
   if (StopBits != 1 && StopBits != 2) begin : g_bad_stop_bits
      $error("uart_tx_frame: StopBits must be 1 or 2");
   end
   if (ParityMode > PARITY_ODD) begin : g_bad_parity
      $error("uart_tx_frame: illegal ParityMode");
   end

   tx_state_t           state_q, state_d;
   logic [DataBits-1:0] shreg_q, shreg_d;
   logic                parity_q, parity_d;
   logic [3:0]          bit_idx_q, bit_idx_d;
   logic                stop_idx_q, stop_idx_d;
   logic                tx_q, tx_d;
   logic                bit_end;
   logic                restart;

   // Hold the counter at zero while idle so the start bit gets a full BitCycles.
   assign restart = (state_q == StIdle) || bit_end;

   uart_baud_timer #(
      .BitCycles(BitCycles)
   ) u_baud_timer (
      .clock  (clock),
      .reset  (reset),
      .restart(restart),
      .bitEnd (bit_end)
   );

   // Next-state and next line value; tx_d is the level for the coming clock.
   always_comb begin
      state_d    = state_q;
      shreg_d    = shreg_q;
      parity_d   = parity_q;
      bit_idx_d  = bit_idx_q;
      stop_idx_d = stop_idx_q;
      tx_d       = tx_q;
      unique case (state_q)
         StIdle: begin
            tx_d = 1'b1;
            if (startTransmission) begin
               state_d  = StStart;
               shreg_d  = data;
               parity_d = (^data) ^ OddParity;
               tx_d     = 1'b0;
            end
         end
         StStart: begin
            if (bit_end) begin
               state_d   = StData;
               bit_idx_d = '0;
               tx_d      = shreg_q[0];
            end
         end
         StData: begin
            if (bit_end) begin
               if (bit_idx_q == LastDataIdx) begin
                  if (ParityMode != PARITY_NONE) begin
                     state_d = StParity;
                     tx_d    = parity_q;
                  end else begin
                     state_d    = StStop;
                     stop_idx_d = 1'b0;
                     tx_d       = 1'b1;
                  end
               end else begin
                  // Shift so the next bit to send always sits at shreg_q[0].
                  bit_idx_d = bit_idx_q + 4'd1;
                  shreg_d   = shreg_q >> 1;
                  tx_d      = shreg_q[1];
               end
            end
         end
         StParity: begin
            if (bit_end) begin
               state_d    = StStop;
               stop_idx_d = 1'b0;
               tx_d       = 1'b1;
            end
         end
         StStop: begin
            tx_d = 1'b1;
            if (bit_end) begin
               if (stop_idx_q == LastStopIdx) begin
                  state_d = StIdle;
               end else begin
                  stop_idx_d = 1'b1;
               end
            end
         end
         default: begin
            state_d = StIdle;
            tx_d    = 1'b1;
         end
      endcase
   end

   // State registers; reset wins over any request in the same cycle.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= StIdle;
         shreg_q    <= '0;
         parity_q   <= 1'b0;
         bit_idx_q  <= '0;
         stop_idx_q <= 1'b0;
         tx_q       <= 1'b1;
      end else begin
         state_q    <= state_d;
         shreg_q    <= shreg_d;
         parity_q   <= parity_d;
         bit_idx_q  <= bit_idx_d;
         stop_idx_q <= stop_idx_d;
         tx_q       <= tx_d;
      end
   end

   assign busy = (state_q != StIdle);
   assign done = (state_q == StStop) && (stop_idx_q == LastStopIdx) && bit_end;
   assign tx   = tx_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Self-checking bench: four transmitter configurations against a slot-based frame model.
module tb_uart_tx_frame;
   import uart_pkg::*;

   localparam int NumDut = 4;
   localparam int BitLen = 10;

   int          cfg_bits [NumDut] = '{8, 8, 8, 7};
   int unsigned cfg_par  [NumDut] = '{PARITY_NONE, PARITY_EVEN, PARITY_ODD, PARITY_NONE};
   int          cfg_stop [NumDut] = '{1, 1, 1, 2};

   logic              clock = 1'b0;
   logic [NumDut-1:0] rst;
   logic [NumDut-1:0] start;
   logic [8:0]        dat [NumDut];
   logic [NumDut-1:0] tx_w;
   logic [NumDut-1:0] busy_w;
   logic [NumDut-1:0] done_w;

   int compared   = 0;
   int mismatched = 0;

   always #5 clock = ~clock;

   uart_tx_frame #(.ClockFrequency(1000000), .BaudRate(100000), .DataBits(8),
                   .ParityMode(PARITY_NONE), .StopBits(1)) u_dut0 (
      .clock(clock), .reset(rst[0]), .startTransmission(start[0]), .data(dat[0][7:0]),
      .busy(busy_w[0]), .done(done_w[0]), .tx(tx_w[0]));

   uart_tx_frame #(.ClockFrequency(1000000), .BaudRate(100000), .DataBits(8),
                   .ParityMode(PARITY_EVEN), .StopBits(1)) u_dut1 (
      .clock(clock), .reset(rst[1]), .startTransmission(start[1]), .data(dat[1][7:0]),
      .busy(busy_w[1]), .done(done_w[1]), .tx(tx_w[1]));

   uart_tx_frame #(.ClockFrequency(1000000), .BaudRate(100000), .DataBits(8),
                   .ParityMode(PARITY_ODD), .StopBits(1)) u_dut2 (
      .clock(clock), .reset(rst[2]), .startTransmission(start[2]), .data(dat[2][7:0]),
      .busy(busy_w[2]), .done(done_w[2]), .tx(tx_w[2]));

   uart_tx_frame #(.ClockFrequency(1000000), .BaudRate(100000), .DataBits(7),
                   .ParityMode(PARITY_NONE), .StopBits(2)) u_dut3 (
      .clock(clock), .reset(rst[3]), .startTransmission(start[3]), .data(dat[3][6:0]),
      .busy(busy_w[3]), .done(done_w[3]), .tx(tx_w[3]));

   task automatic chk(input string tag, input logic obs, input logic exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   // Number of bit slots in one frame.
   function automatic int frame_slots(input int inst);
      return 1 + cfg_bits[inst] + ((cfg_par[inst] != PARITY_NONE) ? 1 : 0) + cfg_stop[inst];
   endfunction

   // Line level of a given bit slot of the frame carrying val.
   function automatic logic slot_value(input int inst, input logic [8:0] val, input int slot);
      int ones;
      ones = 0;
      if (slot == 0) return 1'b0;
      if (slot <= cfg_bits[inst]) return val[slot-1];
      if (cfg_par[inst] != PARITY_NONE && slot == cfg_bits[inst] + 1) begin
         for (int i = 0; i < cfg_bits[inst]; i++) ones += int'(val[i]);
         if (cfg_par[inst] == PARITY_EVEN) return (ones % 2) == 1;
         return (ones % 2) == 0;
      end
      return 1'b1;
   endfunction

   // Send one frame and check every clock. Cycle 0 is the acceptance cycle.
   // pulse_a/pulse_b raise a request mid-frame; chg_cycle alters data; rst_cycle aborts.
   // chain issues the next request in the first idle cycle with next_val.
   task automatic run_frame(input int inst, input logic [8:0] val, input logic preaccepted,
                            input int pulse_a, input int pulse_b, input int chg_cycle,
                            input int rst_cycle, input logic chain, input logic [8:0] next_val);
      int len;
      len = frame_slots(inst) * BitLen;
      if (!preaccepted) begin
         @(negedge clock);
         start[inst] = 1'b1;
         dat[inst]   = val;
      end
      for (int k = 1; k <= len + 1; k++) begin
         @(negedge clock);
         start[inst] = (k == pulse_a) || (k == pulse_b) || (chain && k == len + 1);
         if (rst_cycle != 0 && k == rst_cycle + 1) begin
            chk($sformatf("d%0d.rst.c%0d.tx", inst, k), tx_w[inst], 1'b1);
            chk($sformatf("d%0d.rst.c%0d.busy", inst, k), busy_w[inst], 1'b0);
            chk($sformatf("d%0d.rst.c%0d.done", inst, k), done_w[inst], 1'b0);
            rst[inst] = 1'b0;
            for (int j = 1; j <= len + 20; j++) begin
               @(negedge clock);
               chk($sformatf("d%0d.postrst.c%0d.done", inst, k + j), done_w[inst], 1'b0);
               chk($sformatf("d%0d.postrst.c%0d.busy", inst, k + j), busy_w[inst], 1'b0);
               chk($sformatf("d%0d.postrst.c%0d.tx", inst, k + j), tx_w[inst], 1'b1);
            end
            return;
         end
         if (k <= len) begin
            chk($sformatf("d%0d.c%0d.tx", inst, k), tx_w[inst],
                slot_value(inst, val, (k - 1) / BitLen));
            chk($sformatf("d%0d.c%0d.busy", inst, k), busy_w[inst], 1'b1);
            chk($sformatf("d%0d.c%0d.done", inst, k), done_w[inst], k == len);
         end else begin
            chk($sformatf("d%0d.idle.tx", inst), tx_w[inst], 1'b1);
            chk($sformatf("d%0d.idle.busy", inst), busy_w[inst], 1'b0);
            chk($sformatf("d%0d.idle.done", inst), done_w[inst], 1'b0);
            if (chain) dat[inst] = next_val;
         end
         if (k == chg_cycle) dat[inst] = ~val;
         if (k == rst_cycle) rst[inst] = 1'b1;
      end
   endtask

   initial begin
      int         inst;
      int         pulse;
      logic [8:0] v;
      rst   = '1;
      start = '0;
      for (int i = 0; i < NumDut; i++) dat[i] = '0;
      repeat (3) @(negedge clock);
      for (int i = 0; i < NumDut; i++) begin
         chk($sformatf("d%0d.reset.tx", i), tx_w[i], 1'b1);
         chk($sformatf("d%0d.reset.busy", i), busy_w[i], 1'b0);
         chk($sformatf("d%0d.reset.done", i), done_w[i], 1'b0);
      end
      rst = '0;

      // 8N1, 8E1, 8O1 with 0xA5; 7N2 with 0x7F.
      run_frame(0, 9'h0A5, 1'b0, 0, 0, 0, 0, 1'b0, 9'h000);
      run_frame(1, 9'h0A5, 1'b0, 0, 0, 0, 0, 1'b0, 9'h000);
      run_frame(2, 9'h0A5, 1'b0, 0, 0, 0, 0, 1'b0, 9'h000);
      run_frame(3, 9'h07F, 1'b0, 0, 0, 0, 0, 1'b0, 9'h000);

      // Requests at cycles 30 and 100 ignored; request at 101 starts back-to-back.
      run_frame(0, 9'h03C, 1'b0, 30, 100, 0, 0, 1'b1, 9'h0C3);
      run_frame(0, 9'h0C3, 1'b1, 0, 0, 0, 0, 1'b0, 9'h000);

      // Abort by reset at cycle 45, then a clean frame.
      run_frame(1, 9'h05A, 1'b0, 0, 0, 0, 45, 1'b0, 9'h000);
      run_frame(1, 9'h05A, 1'b0, 0, 0, 0, 0, 1'b0, 9'h000);

      // Data change at cycle 20 has no effect on the line.
      run_frame(2, 9'h096, 1'b0, 0, 0, 20, 0, 1'b0, 9'h000);
      run_frame(3, 9'h035, 1'b0, 0, 0, 20, 0, 1'b0, 9'h000);

      // Random payloads with a stray mid-frame request.
      for (int n = 0; n < 8; n++) begin
         inst  = n % NumDut;
         v     = 9'($urandom_range(0, 511));
         pulse = int'($urandom_range(1, 90));
         run_frame(inst, v, 1'b0, pulse, 0, 0, 0, 1'b0, 9'h000);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
